pulse_stretcher: RTL and testbench

Converts single-cycle request pulses, such as those from the button edge-detect FSM, into fixed-width, human-visible output pulses for LEDs or buzzers. Each accepted request produces exactly one high window on `out` of programmable length, followed by a mandatory low gap. Requests that arrive while a pulse is in progress are counted and replayed back-to-back rather than lost. The block sits between the synchronizer/edge-detect stage and the board I/O, and runs entirely on the board clock with an internal tick divider.

---
 rtl/pulse_stretcher.sv | 114 +++++++++++
 tb/tb_pulse_stretcher.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle request pulses into fixed-width ON windows followed by a forced gap.
// Requests arriving mid-pulse are queued in a saturating counter and replayed back-to-back.
module pulse_stretcher #(
    parameter int unsigned DIV       = 1000000,
    parameter int unsigned ON_TICKS  = 1,
    parameter int unsigned OFF_TICKS = 1,
    parameter int unsigned PW        = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trig,
    output logic          out,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          ovf
);

    localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [CW-1:0] CC_LAST  = CW'(DIV - 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [PW-1:0] P_MAX    = '1;

    typedef enum logic [1:0] {StIdle, StOn, StGap} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cc_q, cc_d;
    logic [TW-1:0] tc_q, tc_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          ovf_q, ovf_d;
    logic          out_q, out_d;
    logic          busy_q, busy_d;
    logic          tick;

    assign tick = (cc_q == CC_LAST);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        ovf_d     = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (trig) state_d = StOn;
            end
            StOn: begin
                if (tick && tc_q == ON_LAST) state_d = StGap;
                if (trig) begin
                    if (pending_q == P_MAX) ovf_d = 1'b1;
                    else                    pending_d = pending_q + PW'(1);
                end
            end
            StGap: begin
                if (tick && tc_q == OFF_LAST) begin
                    // A trig on the final gap edge is served directly (+1-1), never dropped.
                    if (pending_q != '0) begin
                        state_d = StOn;
                        if (!trig) pending_d = pending_q - PW'(1);
                    end else if (trig) begin
                        state_d = StOn;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (trig) begin
                    if (pending_q == P_MAX) ovf_d = 1'b1;
                    else                    pending_d = pending_q + PW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q || state_q == StIdle) begin
            cc_d = '0;
            tc_d = '0;
        end else if (tick) begin
            cc_d = '0;
            tc_d = tc_q + TW'(1);
        end else begin
            cc_d = cc_q + CW'(1);
            tc_d = tc_q;
        end

        out_d  = (state_d == StOn);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cc_q      <= '0;
            tc_q      <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
            out_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cc_q      <= cc_d;
            tc_q      <= tc_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
        end
    end

    assign out     = out_q;
    assign busy    = busy_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: timeline model (pulse start time + queue count) checked every cycle,
// plus literal expectations from the directed scenarios.
module tb_pulse_stretcher;

    localparam int DIV = 4;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PW  = 2;
    localparam int PER = (ON + OFF) * DIV;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          trig;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          ovf;

    pulse_stretcher #(
        .DIV       (DIV),
        .ON_TICKS  (ON),
        .OFF_TICKS (OFF),
        .PW        (PW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .trig    (trig),
        .out     (out),
        .busy    (busy),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int ecur    = 0;
    bit chk_en  = 1'b0;

    // Model: a pulse is "active" from its start edge for PER cycles; ON for the first ON*DIV.
    int gcyc    = 0;
    int m_start = 0;
    int m_pend  = 0;
    bit m_act   = 1'b0;
    bit m_ovf   = 1'b0;

    int d_o [128];
    int d_b [128];
    int d_p [128];
    int d_v [128];
    int m_o [128];
    int m_b [128];
    int m_p [128];
    int m_v [128];

    always @(posedge clk) begin
        gcyc++;
        if (!rst) begin
            m_act  = 1'b0;
            m_pend = 0;
            m_ovf  = 1'b0;
        end else if (!m_act) begin
            if (trig) begin
                m_act   = 1'b1;
                m_start = gcyc;
            end
        end else if (gcyc - m_start == PER) begin
            if (m_pend + int'(trig) > 0) begin
                m_start = gcyc;
                m_pend  = m_pend + int'(trig) - 1;
            end else begin
                m_act = 1'b0;
            end
        end else if (trig) begin
            if (m_pend == PMAX) m_ovf = 1'b1;
            else                m_pend++;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic mo, mb, mv;
            int   mp;
            mo = m_act && ((gcyc - m_start) < ON * DIV);
            mb = m_act;
            mp = m_pend;
            mv = m_ovf;
            vectors += 4;
            if (out !== mo) begin
                fails++;
                $display("FAIL out e=%0d: got %0b want %0b", ecur, out, mo);
            end
            if (busy !== mb) begin
                fails++;
                $display("FAIL busy e=%0d: got %0b want %0b", ecur, busy, mb);
            end
            if (pending !== PW'(mp)) begin
                fails++;
                $display("FAIL pending e=%0d: got %0d want %0d", ecur, pending, mp);
            end
            if (ovf !== mv) begin
                fails++;
                $display("FAIL ovf e=%0d: got %0b want %0b", ecur, ovf, mv);
            end
            d_o[ecur] = int'(out);
            d_b[ecur] = int'(busy);
            d_p[ecur] = int'(pending);
            d_v[ecur] = int'(ovf);
            m_o[ecur] = int'(mo);
            m_b[ecur] = int'(mb);
            m_p[ecur] = mp;
            m_v[ecur] = int'(mv);
        end
    end

    task automatic chk(input string nm, input int dv, input int mv, input int ev);
        vectors += 2;
        if (dv != ev) begin
            fails++;
            $display("FAIL %s dut: got %0d want %0d", nm, dv, ev);
        end
        if (mv != ev) begin
            fails++;
            $display("FAIL %s model: got %0d want %0d", nm, mv, ev);
        end
    endtask

    // Edges 0..2 of every scenario are in reset; extra reset window rlo..rhi.
    task automatic run(input logic [127:0] tm, input int rlo, input int rhi, input int len);
        for (int e = 0; e < len; e++) begin
            rst  = !(e < 3 || (e >= rlo && e <= rhi));
            trig = tm[e];
            ecur = e;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        trig = 1'b0;
    endtask

    task automatic count_rises(input int lo, input int hi, output int dc, output int mc);
        dc = 0;
        mc = 0;
        for (int e = lo; e <= hi; e++) begin
            if (d_o[e] == 1 && d_o[e-1] == 0) dc++;
            if (m_o[e] == 1 && m_o[e-1] == 0) mc++;
        end
    endtask

    initial begin
        logic [127:0] tm;
        int dc, mc;
        rst  = 1'b0;
        trig = 1'b0;
        @(negedge clk);
        #1;
        chk_en = 1'b1;

        // 1: reset with trig toggling
        tm = '0; tm[0] = 1'b1; tm[2] = 1'b1;
        run(tm, -1, -1, 8);
        for (int e = 0; e <= 3; e++) begin
            chk($sformatf("s1_out_%0d", e), d_o[e], m_o[e], 0);
            chk($sformatf("s1_busy_%0d", e), d_b[e], m_b[e], 0);
            chk($sformatf("s1_pend_%0d", e), d_p[e], m_p[e], 0);
            chk($sformatf("s1_ovf_%0d", e), d_v[e], m_v[e], 0);
        end

        // 2: single request
        tm = '0; tm[10] = 1'b1;
        run(tm, -1, -1, 40);
        chk("s2_out9",   d_o[9],  m_o[9],  0);
        chk("s2_out10",  d_o[10], m_o[10], 1);
        chk("s2_out21",  d_o[21], m_o[21], 1);
        chk("s2_out22",  d_o[22], m_o[22], 0);
        chk("s2_busy29", d_b[29], m_b[29], 1);
        chk("s2_busy30", d_b[30], m_b[30], 0);
        chk("s2_pend15", d_p[15], m_p[15], 0);

        // 3: queued request
        tm = '0; tm[10] = 1'b1; tm[15] = 1'b1;
        run(tm, -1, -1, 60);
        chk("s3_pend15", d_p[15], m_p[15], 1);
        chk("s3_out29",  d_o[29], m_o[29], 0);
        chk("s3_out30",  d_o[30], m_o[30], 1);
        chk("s3_pend30", d_p[30], m_p[30], 0);
        chk("s3_out41",  d_o[41], m_o[41], 1);
        chk("s3_out42",  d_o[42], m_o[42], 0);
        chk("s3_busy49", d_b[49], m_b[49], 1);
        chk("s3_busy50", d_b[50], m_b[50], 0);

        // 4: saturation
        tm = '0; tm[10] = 1'b1; tm[12] = 1'b1; tm[14] = 1'b1; tm[16] = 1'b1; tm[18] = 1'b1;
        run(tm, -1, -1, 95);
        chk("s4_pend16", d_p[16], m_p[16], 3);
        chk("s4_ovf17",  d_v[17], m_v[17], 0);
        chk("s4_ovf18",  d_v[18], m_v[18], 1);
        chk("s4_pend18", d_p[18], m_p[18], 3);
        count_rises(1, 94, dc, mc);
        chk("s4_pulses", dc, mc, 4);
        chk("s4_busy90", d_b[90], m_b[90], 0);

        // 5: trig on the final gap edge with a full queue
        tm = '0; tm[10] = 1'b1; tm[12] = 1'b1; tm[14] = 1'b1; tm[16] = 1'b1; tm[30] = 1'b1;
        run(tm, -1, -1, 40);
        chk("s5_pend29", d_p[29], m_p[29], 3);
        chk("s5_out29",  d_o[29], m_o[29], 0);
        chk("s5_out30",  d_o[30], m_o[30], 1);
        chk("s5_pend30", d_p[30], m_p[30], 3);
        chk("s5_ovf30",  d_v[30], m_v[30], 0);

        // 6: reset mid-pulse with two queued
        tm = '0; tm[10] = 1'b1; tm[12] = 1'b1; tm[14] = 1'b1;
        run(tm, 18, 18, 50);
        chk("s6_pend17", d_p[17], m_p[17], 2);
        chk("s6_out17",  d_o[17], m_o[17], 1);
        chk("s6_out18",  d_o[18], m_o[18], 0);
        chk("s6_busy18", d_b[18], m_b[18], 0);
        chk("s6_pend18", d_p[18], m_p[18], 0);
        count_rises(19, 49, dc, mc);
        chk("s6_no_replay", dc + d_b[49], mc + m_b[49], 0);
        chk("s6_ovf49", d_v[49], m_v[49], 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
